// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle,
// with the sign fixed up on the final iteration. Holds the pipeline via stall_E.
//
//   state | meaning
//   IDLE  | waiting for an M op; accepts one the cycle it appears
//   RUN   | iterating, one product/quotient bit per cycle
//   DONE  | result registered and flagged valid for one cycle
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            muldiv_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] src_a_E,
  input  logic [XLEN-1:0] src_b_E,
  input  logic            flush_E,
  output logic            stall_E,
  output logic            busy_E,
  output logic            result_valid_E,
  output logic [XLEN-1:0] muldiv_result_E
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg;
  // hi: product high half / partial remainder; lo: multiplier bits / quotient bits
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   result;

  logic              a_sgn, b_sgn, in_neg;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;
  logic              fast;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_next, mul_lo_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   div_rem_next, div_quo_next;
  logic [XLEN-1:0]   iter_hi, iter_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   final_res;

  // Operand decode at acceptance: signedness, magnitudes, result sign and fast-path detection
  always_comb begin
    a_sgn    = src_a_E[XLEN-1] & (funct3_E == 3'b001 || funct3_E == 3'b010 ||
                                  funct3_E == 3'b100 || funct3_E == 3'b110);
    b_sgn    = src_b_E[XLEN-1] & (funct3_E == 3'b001 || funct3_E == 3'b100 ||
                                  funct3_E == 3'b110);
    in_mag_a = a_sgn ? -src_a_E : src_a_E;
    in_mag_b = b_sgn ? -src_b_E : src_b_E;
    // remainder takes the dividend's sign; everything else the xor of both
    in_neg   = (funct3_E == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
    fast     = 1'b0;
    fast_res = '0;
    if (funct3_E[2]) begin
      if (src_b_E == '0) begin
        fast     = 1'b1;
        fast_res = funct3_E[1] ? src_a_E : '1;
      end else if (!funct3_E[0] && src_a_E == {1'b1, {(XLEN-1){1'b0}}} && src_b_E == '1) begin
        fast     = 1'b1;
        fast_res = funct3_E[1] ? '0 : src_a_E;
      end
    end
  end

  // One multiply or divide iteration, plus the signed/selected result of the final step
  always_comb begin
    mul_sum      = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    mul_hi_next  = mul_sum[XLEN:1];
    mul_lo_next  = {mul_sum[0], lo[XLEN-1:1]};
    div_shift    = {hi, lo[XLEN-1]};
    div_ge       = div_shift >= {1'b0, mag_b};
    div_diff     = div_shift[XLEN-1:0] - mag_b;
    div_rem_next = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_quo_next = {lo[XLEN-2:0], div_ge};
    iter_hi      = op[2] ? div_rem_next : mul_hi_next;
    iter_lo      = op[2] ? div_quo_next : mul_lo_next;
    prod         = {mul_hi_next, mul_lo_next};
    prod_s       = neg ? -prod : prod;
    quo_s        = neg ? -div_quo_next : div_quo_next;
    rem_s        = neg ? -div_rem_next : div_rem_next;
    case (op)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  // Control FSM with operand latching and iteration registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else if (flush_E) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (muldiv_E) begin
            op    <= funct3_E;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            neg   <= in_neg;
            if (fast) begin
              result <= fast_res;
              state  <= DONE;
            end else begin
              hi    <= '0;
              lo    <= funct3_E[2] ? in_mag_a : in_mag_b;
              count <= CW'(XLEN);
              state <= RUN;
            end
          end
        end
        RUN: begin
          hi    <= iter_hi;
          lo    <= iter_lo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result <= final_res;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_E         = ~flush_E & ((state == IDLE & muldiv_E) | (state == RUN));
  assign busy_E          = (state != IDLE);
  assign result_valid_E  = (state == DONE) & ~flush_E;
  assign muldiv_result_E = result;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: plain-arithmetic reference model,
// per-cycle expectations of stall/busy/valid/result, and hand-computed literals.
module tb_execute_muldiv_unit;
  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            muldiv_E;
  logic [2:0]      funct3_E;
  logic [XLEN-1:0] src_a_E;
  logic [XLEN-1:0] src_b_E;
  logic            flush_E;
  logic            stall_E;
  logic            busy_E;
  logic            result_valid_E;
  logic [XLEN-1:0] muldiv_result_E;

  execute_muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST_N(RST_N), .muldiv_E(muldiv_E), .funct3_E(funct3_E),
    .src_a_E(src_a_E), .src_b_E(src_b_E), .flush_E(flush_E), .stall_E(stall_E),
    .busy_E(busy_E), .result_valid_E(result_valid_E), .muldiv_result_E(muldiv_result_E)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_valid = 1'b0, e_busy = 1'b0;
  logic [31:0] e_res = '0;
  logic [31:0] m_last = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    longint la, lb;
    sa = $signed(a);
    sb = $signed(b);
    la = longint'(sa);
    lb = longint'(sb);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = la * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // The single per-cycle compare against the model's expectations
  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall_E", {31'b0, stall_E}, {31'b0, e_stall});
      check("busy_E", {31'b0, busy_E}, {31'b0, e_busy});
      check("result_valid_E", {31'b0, result_valid_E}, {31'b0, e_valid});
      check("muldiv_result_E", muldiv_result_E, e_res);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    muldiv_E = 1'b0; flush_E = 1'b0;
    e_stall = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_res = m_last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      step();
    end
  endtask

  // Cycle-by-cycle drive of one op; operands are scrambled after acceptance
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, output int vcyc);
    logic [31:0] exp;
    int lat;
    exp = model(f, a, b);
    check("model_pin", exp, lit);
    lat = is_fast(f, a, b) ? 1 : XLEN + 1;
    vcyc = -1;
    for (int c = 0; c <= lat; c++) begin
      muldiv_E = 1'b1; flush_E = 1'b0;
      if (c == 0) begin
        funct3_E = f; src_a_E = a; src_b_E = b;
      end else begin
        funct3_E = 3'($urandom); src_a_E = $urandom; src_b_E = $urandom;
      end
      e_stall = (c < lat); e_valid = (c == lat); e_busy = (c > 0);
      if (c == lat) begin
        m_last = exp;
        vcyc = cyc;
      end
      e_res = m_last;
      step();
    end
    set_idle();
  endtask

  int v1, v2, vd;

  initial begin
    RST_N = 1'b0; muldiv_E = 1'b0; flush_E = 1'b0;
    funct3_E = '0; src_a_E = '0; src_b_E = '0;
    #3;
    check("rst_stall", {31'b0, stall_E}, 32'd0);
    check("rst_busy", {31'b0, busy_E}, 32'd0);
    check("rst_valid", {31'b0, result_valid_E}, 32'd0);
    check("rst_result", muldiv_result_E, 32'd0);
    #9 RST_N = 1'b1;
    step();
    set_idle();
    chk_en = 1'b1;
    idle(2);

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, vd);
    idle(1);
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, vd);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, vd);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, vd);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, vd);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, vd);
    do_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, vd);
    do_op(3'd7, 32'd5,        32'd0,        32'd5,        vd);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, vd);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        vd);
    do_op(3'd4, 32'd100,      32'd0,        32'hFFFFFFFF, vd);
    do_op(3'd1, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, vd);
    do_op(3'd5, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, vd);
    do_op(3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, vd);
    do_op(3'd0, 32'h00010001, 32'h00010001, 32'h00020001, vd);
    do_op(3'd3, 32'h00010001, 32'h00010001, 32'h00000001, vd);
    do_op(3'd5, 32'd1000,     32'd7,        32'h0000008E, vd);
    do_op(3'd7, 32'd1000,     32'd7,        32'd6,        vd);
    idle(2);

    // flush during cycle 10 of an op: no result, back to idle
    for (int c = 0; c <= 10; c++) begin
      muldiv_E = 1'b1;
      funct3_E = (c == 0) ? 3'd0 : 3'($urandom);
      src_a_E = 32'h1234; src_b_E = 32'h5678;
      flush_E = (c == 10);
      e_stall = (c < 10); e_busy = (c > 0); e_valid = 1'b0; e_res = m_last;
      step();
    end
    idle(40);

    // flush wins over a new op presented in idle
    muldiv_E = 1'b1; flush_E = 1'b1; funct3_E = 3'd0; src_a_E = 32'd3; src_b_E = 32'd4;
    e_stall = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_res = m_last;
    step();
    idle(3);

    // asynchronous reset mid-run
    do_op(3'd0, 32'd9, 32'd9, 32'd81, vd);
    for (int c = 0; c <= 5; c++) begin
      muldiv_E = 1'b1; flush_E = 1'b0; funct3_E = 3'd3;
      src_a_E = 32'hDEAD; src_b_E = 32'hBEEF;
      e_stall = 1'b1; e_busy = (c > 0); e_valid = 1'b0; e_res = m_last;
      step();
    end
    chk_en = 1'b0;
    RST_N = 1'b0; muldiv_E = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy_E}, 32'd0);
    check("arst_stall", {31'b0, stall_E}, 32'd0);
    check("arst_valid", {31'b0, result_valid_E}, 32'd0);
    check("arst_result", muldiv_result_E, 32'd0);
    #1 RST_N = 1'b1;
    m_last = '0;
    set_idle();
    chk_en = 1'b1;
    step();
    idle(2);

    // back-to-back ops: two results 34 cycles apart
    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, v1);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, v2);
    check("b2b_gap", 32'(v2 - v1), 32'd34);
    idle(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
